// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [31:0] NOP_INST        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF     = 4;
  localparam logic [31:0] WORD_ALIGN_MASK = ~32'h3;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: pipeline control in, ROM request/response, IF/ID out.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              stall;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic              if_valid;

  // Fetch unit side.
  modport master (
    input  stall, branch_en, branch_target, flush, flush_pc, rom_data,
    output rom_ce, rom_addr, if_pc, if_inst, if_valid
  );

  // Pipeline / ROM side.
  modport slave (
    output stall, branch_en, branch_target, flush, flush_pc, rom_data,
    input  rom_ce, rom_addr, if_pc, if_inst, if_valid
  );

endinterface : inst_fetch_if

// File: rtl/inst_fetch_pc_reg.sv
// Program counter and ROM chip-enable with next-PC selection.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              rom_ce_o
);

  // Low two bits cleared, upper bits set, for any address width.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(~WORD_ALIGN_MASK);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;

  // Next-PC selection: flush beats stall beats branch beats increment.
  always_comb begin
    pc_d = pc_q;
    ce_d = ENABLE;
    if (ce_q == DISABLE) begin
      pc_d = pc_q;
    end else if (flush_i) begin
      pc_d = flush_pc_i & ALIGN_MASK;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (branch_en_i) begin
      pc_d = branch_target_i & ALIGN_MASK;
    end else begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // PC and chip-enable state; chip-enable rises on the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC & ALIGN_MASK;
      ce_q <= DISABLE;
    end else begin
      pc_q <= pc_d;
      ce_q <= ce_d;
    end
  end

  assign pc_o     = pc_q;
  assign rom_ce_o = ce_q;

endmodule : inst_fetch_pc_reg

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the ROM and captures the IF/ID register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master fetch_bus
);

  logic [ADDR_W-1:0] pc;
  logic              rom_ce;

  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (fetch_bus.stall),
    .branch_en_i     (fetch_bus.branch_en),
    .branch_target_i (fetch_bus.branch_target),
    .flush_i         (fetch_bus.flush),
    .flush_pc_i      (fetch_bus.flush_pc),
    .pc_o            (pc),
    .rom_ce_o        (rom_ce)
  );

  // IF/ID next value: bubble while ROM is off or on flush, hold on stall.
  always_comb begin
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if (rom_ce == DISABLE || fetch_bus.flush) begin
      if_pc_d    = '0;
      if_inst_d  = DATA_W'(NOP_INST);
      if_valid_d = DISABLE;
    end else if (!fetch_bus.stall) begin
      if_pc_d    = pc;
      if_inst_d  = fetch_bus.rom_data;
      if_valid_d = ENABLE;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc_q    <= '0;
      if_inst_q  <= DATA_W'(NOP_INST);
      if_valid_q <= DISABLE;
    end else begin
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign fetch_bus.rom_ce   = rom_ce;
  assign fetch_bus.rom_addr = pc;
  assign fetch_bus.if_pc    = if_pc_q;
  assign fetch_bus.if_inst  = if_inst_q;
  assign fetch_bus.if_valid = if_valid_q;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a behavioural fetch model.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_bus (bus)
  );

  // ROM contents: two fixed words at the bottom, a hash of the address elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    if (a == 32'h4) return 32'h2002_0007;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus.rom_data = bus.rom_ce ? rom_word(bus.rom_addr) : {32{1'bz}};

  int n_vec = 0;
  int n_err = 0;

  // Model state: architectural PC, chip-enable, and the IF/ID contents.
  logic [31:0] m_pc, m_if_pc, m_if_inst;
  logic        m_ce, m_valid;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk_val("rom_ce",   {31'b0, bus.rom_ce},   {31'b0, m_ce});
    chk_val("rom_addr", bus.rom_addr,          m_pc);
    chk_val("if_pc",    bus.if_pc,             m_if_pc);
    chk_val("if_inst",  bus.if_inst,           m_if_inst);
    chk_val("if_valid", {31'b0, bus.if_valid}, {31'b0, m_valid});
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_ce      = 1'b0;
    m_if_pc   = 32'h0;
    m_if_inst = 32'h0;
    m_valid   = 1'b0;
  endtask

  task automatic model_bubble();
    m_if_pc   = 32'h0;
    m_if_inst = 32'h0;
    m_valid   = 1'b0;
  endtask

  // One clock edge of the fetch stage, from the inputs applied at that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!m_ce) begin
      m_ce = 1'b1;
      model_bubble();
    end else if (bus.flush) begin
      m_pc = {bus.flush_pc[31:2], 2'b00};
      model_bubble();
    end else if (bus.stall) begin
      // everything holds
    end else begin
      m_if_pc   = m_pc;
      m_if_inst = rom_word(m_pc);
      m_valid   = 1'b1;
      if (bus.branch_en) m_pc = {bus.branch_target[31:2], 2'b00};
      else               m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] fp);
    bus.stall         = st;
    bus.branch_en     = br;
    bus.branch_target = bt;
    bus.flush         = fl;
    bus.flush_pc      = fp;
  endtask

  // Reset pulse placed entirely between two clock edges.
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    #1;
    check_all();
    repeat (2) step();
    #3 rst = 1'b0;

    // Reset release and first two fetches.
    step();
    chk_val("tp_ce_rise", {31'b0, bus.rom_ce}, 32'h1);
    step();
    chk_val("tp_first_inst", bus.if_inst, 32'h2001_0005);
    step();
    chk_val("tp_second_inst", bus.if_inst, 32'h2002_0007);

    // Three-cycle stall at pc=0x8, then release.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    chk_val("tp_stall_addr", bus.rom_addr, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk_val("tp_stall_release_pc", bus.if_pc, 32'h8);
    step();
    chk_val("tp_after_stall_pc", bus.if_pc, 32'hC);

    // Branch with delay slot, unaligned target.
    drive(1'b0, 1'b1, 32'h0000_0041, 1'b0, 32'h0);
    step();
    chk_val("tp_delay_slot_pc", bus.if_pc, 32'h10);
    chk_val("tp_branch_addr", bus.rom_addr, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk_val("tp_branch_dest_pc", bus.if_pc, 32'h40);

    // Flush overrides stall and branch.
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h180);
    step();
    chk_val("tp_flush_addr", bus.rom_addr, 32'h180);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk_val("tp_flush_dest_pc", bus.if_pc, 32'h180);

    // Wrap-around from the top word.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk_val("tp_top_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk_val("tp_wrap_addr", bus.rom_addr, 32'h0);
    step();

    // Async reset with pc=0x24.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h24);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_val("tp_pre_reset_addr", bus.rom_addr, 32'h24);
    async_reset_pulse();
    step();
    step();
    chk_val("tp_post_reset_inst", bus.if_inst, 32'h2001_0005);

    // Random control traffic.
    for (int i = 0; i < 600; i++) begin
      logic st, br, fl;
      st = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 15) == 0);
      drive(st, br, $urandom, fl, $urandom);
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_inst_fetch

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator for the single-issue MIPS core; the requester side of the instruction ROM interface.
- Owns the PC register and drives ROM chip-enable and byte address.
- Samples the 32-bit big-endian instruction word the ROM returns combinationally and registers it, with its PC, into the IF/ID pipeline register.
- Handles stall, branch redirect (MIPS delay-slot semantics) and exception flush.

Parameters:
- ADDR_W, 32, width of PC and ROM byte address.
- DATA_W, 32, instruction / ROM data width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID (hazard from later stage).
- branch_en  input  1  taken branch/jump resolved in ID.
- branch_target  input  ADDR_W  branch destination byte address.
- flush  input  1  exception/eret redirect; kills the IF/ID contents.
- flush_pc  input  ADDR_W  redirect address for flush.
- rom_ce  output  1  ROM chip-enable (1 = read).
- rom_addr  output  ADDR_W  ROM byte address, always word aligned.
- rom_data  input  DATA_W  instruction word from ROM; high-Z when rom_ce=0.
- if_pc  output  ADDR_W  PC of the registered instruction.
- if_inst  output  DATA_W  registered instruction.
- if_valid  output  1  if_inst is a real fetched instruction (0 = bubble).

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - pc=RESET_PC, rom_ce=0.
  - if_pc=0, if_inst=32'h0000_0000 (NOP), if_valid=0.
- rom_ce:
  - Register; becomes 1 on the first rising edge after rst deasserts, then stays 1 until the next reset.
  - While rom_ce=0: pc holds and IF/ID loads a bubble, so a high-Z rom_data is never sampled.
- rom_addr:
  - Combinational copy of pc.
  - pc[1:0] is always 00: every load into pc masks bits [1:0] to zero, including branch_target and flush_pc.
- Fetch latency: ROM read is combinational; the instruction at pc appears on if_inst one clock after pc is presented.
- Per-edge priority when rom_ce=1, highest first:
  1. flush=1:
     - pc <= flush_pc & ~3.
     - IF/ID <= bubble (if_inst=0, if_valid=0, if_pc=0).
     - Overrides stall and branch_en.
  2. stall=1:
     - pc, if_pc, if_inst, if_valid all hold.
     - branch_en is ignored; the requester holds branch_en until stall drops.
  3. branch_en=1:
     - IF/ID <= {pc, rom_data, 1}; this is the delay slot, captured normally.
     - pc <= branch_target & ~3.
  4. Otherwise:
     - IF/ID <= {pc, rom_data, 1}.
     - pc <= pc + PC_STEP.
- Arithmetic: pc + PC_STEP is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Reset mid-operation: asynchronous clear of every register regardless of stall/flush. The first fetch after release is from RESET_PC, one cycle after rom_ce rises.
- A stall lasting N cycles produces exactly one IF/ID entry for the held PC; no instruction is duplicated or dropped.
- No combinational path from stall/branch_en/flush to rom_addr.

Decomposition:
- Shared package/header inst_fetch_pkg:
  - ENABLE/DISABLE constants.
  - NOP_INST = 32'h0.
  - RESET_PC, PC_STEP, ADDR_W, DATA_W defaults.
  - WORD_ALIGN_MASK = ~32'h3.
- One natural sub-module, pc_reg:
  - Holds the PC and the rom_ce register.
  - Implements next-PC selection (flush / stall / branch / increment) and alignment masking.
- The IF/ID register stays in inst_fetch.

Test Plan:
- Reset release:
  - Stimulus: rst 1->0; ROM holds 0x2001_0005 at 0x0 and 0x2002_0007 at 0x4.
  - Response: rom_ce=0 and if_valid=0 during reset; rom_ce=1 after edge 1. After edge 2: if_pc=0x0, if_inst=0x2001_0005, if_valid=1. After edge 3: if_pc=0x4, if_inst=0x2002_0007.
- Stall:
  - Stimulus: stall=1 for 3 cycles with pc=0x8.
  - Response: rom_addr stays 0x8 and if_inst/if_pc unchanged for 3 edges. After release, if_pc=0x8 exactly once, then 0xC.
- Branch with delay slot:
  - Stimulus: branch_en=1, branch_target=0x0000_0041 while pc=0x10.
  - Response: next if_pc=0x10 (delay slot, valid=1); rom_addr=0x40; following if_pc=0x40.
- Flush priority:
  - Stimulus: flush=1, stall=1, branch_en=1, flush_pc=0x180, branch_target=0x40.
  - Response: if_valid=0, if_inst=0, rom_addr=0x180; next if_pc=0x180.
- Wrap-around:
  - Stimulus: branch_target=0xFFFF_FFFC.
  - Response: if_pc=0xFFFF_FFFC, then rom_addr=0x0000_0000 with no X.
- Async reset mid-stream:
  - Stimulus: rst pulsed high between edges while pc=0x24.
  - Response: outputs clear immediately without waiting for clk; pc=RESET_PC and rom_ce=0 until the edge after release.
